// File: rtl/ls_sequencer.sv
// Purpose : load/store sequencer that turns a SPARC ld/st request into MAR/MDR/RAM/register-file strobes.
// Latency : start edge to done is 4 cycles for a single word and 7 for a double word, plus 1 per extra MEM wait cycle; traps come 1 cycle after start.
// Backpr. : start is sampled only in IDLE and ignored while busy (no queuing); MEM stalls until MFC.
// Ports   : Clk/RESET_n; request start, op, rd, addr_lo; memory handshake MFC;
//           status busy, done, trap, trap_cause; datapath strobes MAR_Enable, MDR_Enable,
//           MDR_Mux_select, RAM_enable, RAM_OpCode, register_file, rf_sel, beat.
// Config  : define LS_TIMEOUT_EN to trap (cause 11) after TO_CYCLES MEM cycles without MFC.
module ls_sequencer #(
   parameter int TO_CYCLES = 16,
   parameter int RSEL_W    = 5
) (
   input  logic              Clk,
   input  logic              RESET_n,
   input  logic              start,
   input  logic [5:0]        op,
   input  logic [RSEL_W-1:0] rd,
   input  logic [2:0]        addr_lo,
   input  logic              MFC,
   output logic              busy,
   output logic              MAR_Enable,
   output logic              MDR_Enable,
   output logic              MDR_Mux_select,
   output logic              RAM_enable,
   output logic              register_file,
   output logic [5:0]        RAM_OpCode,
   output logic [RSEL_W-1:0] rf_sel,
   output logic              beat,
   output logic              done,
   output logic              trap,
   output logic [1:0]        trap_cause
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, WB, DONE, TRAP} state_t;

   state_t            state_q, state_d;
   logic [5:0]        op_q;
   logic [RSEL_W-1:0] rd_q;
   logic              ld_q, dbl_q, beat_q, beat_d;
   logic [1:0]        cause_d;
   logic              mdr_data_q;

   function automatic logic is_load(input logic [5:0] o);
      return (o[5:2] == 4'b0000) || (o == 6'b001001) || (o == 6'b001010);
   endfunction

   function automatic logic is_store(input logic [5:0] o);
      return o[5:2] == 4'b0001;
   endfunction

   // op[1:0] encodes the access size for every legal op: 00 word, 01 byte, 10 half, 11 double.
   function automatic logic misaligned(input logic [5:0] o, input logic [2:0] a, input logic r0);
      case (o[1:0])
         2'b01:   misaligned = 1'b0;
         2'b10:   misaligned = a[0];
         2'b00:   misaligned = |a[1:0];
         default: misaligned = (|a) | r0;
      endcase
   endfunction

`ifdef LS_TIMEOUT_EN
   logic [7:0] to_cnt_q;
`endif

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cause_d = 2'b00;
      case (state_q)
         IDLE: if (start) begin
            if (!is_load(op) && !is_store(op)) begin
               state_d = TRAP;
               cause_d = 2'b01;
            end else if (misaligned(op, addr_lo, rd[0])) begin
               state_d = TRAP;
               cause_d = 2'b10;
            end else begin
               state_d = ADDR;
               beat_d  = 1'b0;
            end
         end
         ADDR: state_d = ld_q ? MEM : DATA;
         DATA: state_d = MEM;
         MEM: begin
            if (MFC) begin
               if (ld_q) begin
                  state_d = WB;
               end else if (dbl_q && !beat_q) begin
                  state_d = ADDR;
                  beat_d  = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
`ifdef LS_TIMEOUT_EN
            // MFC arriving on the final allowed cycle still completes the access.
            else if (to_cnt_q == 8'(TO_CYCLES - 1)) begin
               state_d = TRAP;
               cause_d = 2'b11;
            end
`endif
         end
         WB: begin
            if (dbl_q && !beat_q) begin
               state_d = ADDR;
               beat_d  = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef LS_TIMEOUT_EN
   // Counts consecutive MEM cycles of the current beat; restarts on every MEM exit.
   always_ff @(posedge Clk or negedge RESET_n) begin
      if (!RESET_n)
         to_cnt_q <= 8'd0;
      else if (state_q == MEM && state_d == MEM)
         to_cnt_q <= to_cnt_q + 8'd1;
      else
         to_cnt_q <= 8'd0;
   end
`endif

   // Outputs are registered from the next state so each strobe lines up with its state cycle.
   always_ff @(posedge Clk or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q        <= IDLE;
         op_q           <= 6'd0;
         rd_q           <= '0;
         ld_q           <= 1'b0;
         dbl_q          <= 1'b0;
         beat_q         <= 1'b0;
         busy           <= 1'b0;
         MAR_Enable     <= 1'b0;
         mdr_data_q     <= 1'b0;
         MDR_Mux_select <= 1'b0;
         RAM_enable     <= 1'b0;
         RAM_OpCode     <= 6'd0;
         register_file  <= 1'b0;
         rf_sel         <= '0;
         beat           <= 1'b0;
         done           <= 1'b0;
         trap           <= 1'b0;
         trap_cause     <= 2'b00;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (state_q == IDLE && state_d == ADDR) begin
            op_q  <= op;
            rd_q  <= rd;
            ld_q  <= is_load(op);
            dbl_q <= (op[1:0] == 2'b11);
         end
         busy           <= (state_d != IDLE);
         MAR_Enable     <= (state_d == ADDR);
         mdr_data_q     <= (state_d == DATA);
         MDR_Mux_select <= (state_d == MEM) && ld_q;
         RAM_enable     <= (state_d == MEM);
         // Double-word beats issue plain word ops; the +4 address comes from beat upstream.
         RAM_OpCode     <= (state_d != MEM) ? 6'd0 :
                           dbl_q ? (ld_q ? 6'b000000 : 6'b000100) : op_q;
         register_file  <= (state_d == WB);
         rf_sel         <= (state_d == DATA || state_d == WB) ?
                           (beat_d ? {rd_q[RSEL_W-1:1], 1'b1} : rd_q) : '0;
         beat           <= (state_d == ADDR || state_d == DATA || state_d == MEM || state_d == WB)
                           ? beat_d : 1'b0;
         done           <= (state_d == DONE);
         trap           <= (state_d == TRAP);
         trap_cause     <= (state_d == TRAP) ? cause_d : 2'b00;
      end
   end

   // Loads capture read data into MDR on the very cycle memory signals completion.
   assign MDR_Enable = mdr_data_q | (MDR_Mux_select & MFC);

endmodule

// File: tb/tb_ls_sequencer.sv
module tb_ls_sequencer;

   logic       Clk = 1'b0;
   logic       RESET_n = 1'b0;
   logic       start = 1'b0;
   logic       MFC = 1'b0;
   logic [5:0] op = 6'd0;
   logic [4:0] rd = 5'd0;
   logic [2:0] addr_lo = 3'd0;
   logic       busy, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, register_file;
   logic [5:0] RAM_OpCode;
   logic [4:0] rf_sel;
   logic       beat, done, trap;
   logic [1:0] trap_cause;

   always #5 Clk = ~Clk;

   ls_sequencer #(.TO_CYCLES(16), .RSEL_W(5)) dut (
      .Clk(Clk), .RESET_n(RESET_n), .start(start), .op(op), .rd(rd), .addr_lo(addr_lo),
      .MFC(MFC), .busy(busy), .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable),
      .MDR_Mux_select(MDR_Mux_select), .RAM_enable(RAM_enable), .register_file(register_file),
      .RAM_OpCode(RAM_OpCode), .rf_sel(rf_sel), .beat(beat), .done(done), .trap(trap),
      .trap_cause(trap_cause)
   );

   // One request and everything the bench expects to observe for it.
   typedef struct {
      logic [5:0] op;
      logic [4:0] rd;
      logic [2:0] a;
      int         wait_n;   // extra MEM cycles per beat before MFC
      logic       trap;
      logic [1:0] cause;
      int         lat;      // cycle index of the done/trap pulse
      int         mar;      // MAR_Enable pulses
      int         wb;       // register_file pulses
      logic [5:0] opc;      // RAM_OpCode on the first MEM cycle
      logic [4:0] sel;      // rf_sel on the last DATA/WB cycle
      logic       bt;       // beat on that same cycle
   } vec_t;

   vec_t vt[17];
   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {busy, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, register_file,
              RAM_OpCode, rf_sel, beat, done, trap, trap_cause};
   endfunction

   task automatic run_vec(input vec_t v, input int tag);
      int         mar_n = 0, wb_n = 0, mem_n = 0, lat = 0;
      logic [5:0] opc = 6'd0;
      logic [4:0] sel = 5'd0;
      logic       bt = 1'b0, seen_opc = 1'b0, got_trap = 1'b0;
      logic [1:0] cause = 2'b00;
      vec_t       e;
      @(negedge Clk);
      op = v.op; rd = v.rd; addr_lo = v.a; start = 1'b1; MFC = 1'b0;
      exp_q.push_back(v);
      @(posedge Clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         if (MAR_Enable) mar_n++;
         if (RAM_enable && !seen_opc) begin opc = RAM_OpCode; seen_opc = 1'b1; end
         if (register_file || (MDR_Enable && !MDR_Mux_select)) begin sel = rf_sel; bt = beat; end
         if (register_file) wb_n++;
         if (done || trap) begin lat = k; got_trap = trap; cause = trap_cause; break; end
         if (RAM_enable) begin MFC = (mem_n >= v.wait_n); mem_n++; end
         else begin MFC = 1'b0; mem_n = 0; end
         @(posedge Clk); #1;
      end
      MFC = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("v%0d latency", tag), lat, e.lat);
      check($sformatf("v%0d trap", tag), got_trap, e.trap);
      check($sformatf("v%0d cause", tag), cause, e.cause);
      check($sformatf("v%0d mar", tag), mar_n, e.mar);
      check($sformatf("v%0d wb", tag), wb_n, e.wb);
      check($sformatf("v%0d opcode", tag), opc, e.opc);
      check($sformatf("v%0d rf_sel", tag), sel, e.sel);
      check($sformatf("v%0d beat", tag), bt, e.bt);
      @(posedge Clk); #1;
      check($sformatf("v%0d idle busy", tag), busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   done_at, trap_seen;
      vec_t tv;
      //          op         rd     a     w  trap cause lat mar wb opc        sel    bt
      vt[0]  = '{6'b000000, 5'd3,  3'd0, 0, 1'b0, 2'd0, 4, 1, 1, 6'b000000, 5'd3,  1'b0};
      vt[1]  = '{6'b000001, 5'd9,  3'd3, 0, 1'b0, 2'd0, 4, 1, 1, 6'b000001, 5'd9,  1'b0};
      vt[2]  = '{6'b000010, 5'd1,  3'd2, 2, 1'b0, 2'd0, 6, 1, 1, 6'b000010, 5'd1,  1'b0};
      vt[3]  = '{6'b000011, 5'd6,  3'd0, 0, 1'b0, 2'd0, 7, 2, 2, 6'b000000, 5'd7,  1'b1};
      vt[4]  = '{6'b001001, 5'd31, 3'd7, 0, 1'b0, 2'd0, 4, 1, 1, 6'b001001, 5'd31, 1'b0};
      vt[5]  = '{6'b001010, 5'd2,  3'd6, 1, 1'b0, 2'd0, 5, 1, 1, 6'b001010, 5'd2,  1'b0};
      vt[6]  = '{6'b000100, 5'd5,  3'd4, 0, 1'b0, 2'd0, 4, 1, 0, 6'b000100, 5'd5,  1'b0};
      vt[7]  = '{6'b000101, 5'd8,  3'd1, 0, 1'b0, 2'd0, 4, 1, 0, 6'b000101, 5'd8,  1'b0};
      vt[8]  = '{6'b000110, 5'd12, 3'd2, 3, 1'b0, 2'd0, 7, 1, 0, 6'b000110, 5'd12, 1'b0};
      vt[9]  = '{6'b000111, 5'd4,  3'd0, 1, 1'b0, 2'd0, 9, 2, 0, 6'b000100, 5'd5,  1'b1};
      vt[10] = '{6'b000010, 5'd0,  3'd1, 0, 1'b1, 2'd2, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[11] = '{6'b111111, 5'd3,  3'd0, 0, 1'b1, 2'd1, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[12] = '{6'b001000, 5'd1,  3'd1, 0, 1'b1, 2'd1, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[13] = '{6'b000000, 5'd2,  3'd2, 0, 1'b1, 2'd2, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[14] = '{6'b000011, 5'd5,  3'd0, 0, 1'b1, 2'd2, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[15] = '{6'b000111, 5'd2,  3'd4, 0, 1'b1, 2'd2, 1, 0, 0, 6'b000000, 5'd0,  1'b0};
      vt[16] = '{6'b000110, 5'd0,  3'd1, 0, 1'b1, 2'd2, 1, 0, 0, 6'b000000, 5'd0,  1'b0};

      #1;
      check("reset outputs", all_outs(), 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      RESET_n = 1'b1;

      for (int i = 0; i < 17; i++) run_vec(vt[i], i);

      // start held high with a junk op while busy must not disturb the running load
      @(negedge Clk);
      op = 6'b000000; rd = 5'd1; addr_lo = 3'd0; start = 1'b1; MFC = 1'b1;
      @(posedge Clk); #1;
      op = 6'b111111;
      done_at = 0; trap_seen = 0;
      for (int k = 1; k <= 4; k++) begin
         if (done) done_at = k;
         if (trap) trap_seen = 1;
         if (k == 4) start = 1'b0;
         @(posedge Clk); #1;
      end
      check("busy start done", done_at, 4);
      check("busy start trap", trap_seen, 0);
      check("busy start idle", busy, 1'b0);

      // reset during the second-beat MEM of a std
      @(negedge Clk);
      op = 6'b000111; rd = 5'd4; addr_lo = 3'd0; start = 1'b1; MFC = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      MFC = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("std beat1 mem", {RAM_enable, beat, RAM_OpCode}, {1'b1, 1'b1, 6'b000100});
      RESET_n = 1'b0;
      #1;
      check("reset mid std", all_outs(), 32'd0);
      repeat (2) @(posedge Clk);
      #1;
      check("reset held", all_outs(), 32'd0);
      @(negedge Clk);
      RESET_n = 1'b1;
      op = 6'b000000; rd = 5'd3; addr_lo = 3'd0; start = 1'b1; MFC = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      check("first req mar", MAR_Enable, 1'b1);
      done_at = 0; trap_seen = 0;
      for (int k = 1; k <= 6; k++) begin
         if (done && done_at == 0) done_at = k;
         if (trap) trap_seen = 1;
         @(posedge Clk); #1;
      end
      check("post reset done", done_at, 4);
      check("post reset trap", trap_seen, 0);
      MFC = 1'b0;

`ifdef LS_TIMEOUT_EN
      tv = '{6'b000100, 5'd5, 3'd0, 1000, 1'b1, 2'd3, 19, 1, 0, 6'b000100, 5'd5, 1'b0};
      run_vec(tv, 100);
      tv = '{6'b000100, 5'd5, 3'd0, 15, 1'b0, 2'd0, 19, 1, 0, 6'b000100, 5'd5, 1'b0};
      run_vec(tv, 101);
`else
      tv = '{6'b000100, 5'd5, 3'd0, 30, 1'b0, 2'd0, 34, 1, 0, 6'b000100, 5'd5, 1'b0};
      run_vec(tv, 100);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
